// File: rtl/bitmask_scan_pkg.sv
// Shared constants, FSM encoding and bit helpers for bitmask_scanner.
// Contents: WIDTH, IDX_W, state_t (S_IDLE/S_SCAN), onehot().
package bitmask_scan_pkg;

   localparam int WIDTH = 32;
   localparam int IDX_W = 5;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SCAN = 1'b1
   } state_t;

   function automatic logic [WIDTH-1:0] onehot(
      input logic [IDX_W-1:0] idx
   );
      logic [WIDTH-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/leadingZero32.sv
// 32-bit leading-zero counter; count is 32 for an all-zero value.
// Ports: value (in, 32), count (out, 6).
module leadingZero32 (
   input  logic [31:0] value,
   output logic [5:0]  count
);

   // Walk upward so the highest set bit makes the final assignment.
   always_comb begin
      count = 6'd32;
      for (int i = 0; i < 32; i++) begin
         if (value[i]) count = 6'(31 - i);
      end
   end

endmodule

// File: rtl/bitmask_scanner.sv
// Emits set-bit indices of a 32-bit mask, MSB first, one per cycle.
// Ports: clk, reset (async high), in_valid/in_ready/in_mask,
//   out_valid/out_ready/out_index, done; out_last with
//   BITMASK_SCAN_LAST_EN defined.
module bitmask_scanner
   import bitmask_scan_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_mask,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_index,
   output logic             done
`ifdef BITMASK_SCAN_LAST_EN
   ,
   output logic             out_last
`endif
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] remain;
   logic [IDX_W-1:0] hi_idx, index_d;
   logic [5:0]       lz;
   logic             empty, load;
   logic             valid_d, done_d;

   leadingZero32 u_lzc (
      .value (mask_q),
      .count (lz)
   );

   // lz < 32 means lz fits in 5 bits, and 31 - lz is its complement.
   assign empty  = lz[5];
   assign hi_idx = ~lz[IDX_W-1:0];
   assign remain = mask_q & ~onehot(hi_idx);
   assign load   = ~out_valid | out_ready;

   assign in_ready = (state_q == S_IDLE);

`ifdef BITMASK_SCAN_LAST_EN
   logic last_d;
`endif

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      index_d = out_index;
      valid_d = out_valid;
      done_d  = 1'b0;
`ifdef BITMASK_SCAN_LAST_EN
      last_d  = out_last;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               mask_d  = in_mask;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (load && !empty) begin
               index_d = hi_idx;
               valid_d = 1'b1;
               mask_d  = remain;
`ifdef BITMASK_SCAN_LAST_EN
               last_d  = (remain == '0);
`endif
            end else if (load) begin
               valid_d = 1'b0;
               done_d  = 1'b1;
               state_d = S_IDLE;
`ifdef BITMASK_SCAN_LAST_EN
               last_d  = 1'b0;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         mask_q    <= '0;
         out_index <= '0;
         out_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         out_index <= index_d;
         out_valid <= valid_d;
         done      <= done_d;
      end
   end

`ifdef BITMASK_SCAN_LAST_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) out_last <= 1'b0;
      else       out_last <= last_d;
   end
`endif

endmodule

// File: doc/bitmask_scanner.md
# bitmask_scanner

Sequential set-bit enumerator that consumes a 32-bit occupancy mask and emits, one per cycle, the index of every set bit, MSB first. Each step uses the 32-bit leading-zero counter to locate the highest set bit, clears it, and repeats until the mask is empty. It sits between buffet slot/valid bitmaps and index consumers such as the fill/drain address generators.

## Interface
- WIDTH, 32: mask width. Only 32 is supported; it is fixed by the leading-zero counter.
- IDX_W, 5: output index width, log2(WIDTH).

Ports:
- clk  in  1  clock; all flops rise-edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  mask offered.
- in_ready  out  1  block idle and able to accept a mask.
- in_mask  in  32  mask to enumerate.
- out_valid  out  1  out_index valid.
- out_ready  in  1  consumer accepts out_index.
- out_index  out  5  bit position of the current set bit (31..0).
- done  out  1  one-cycle pulse: the current mask is fully enumerated.

## Operation
- FSM states: IDLE and SCAN.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: mask_q <= in_mask; go to SCAN.
- SCAN:
  - lz = leading-zero count of mask_q (0..32).
  - Output-register load condition: out_valid == 0, or out_valid & out_ready.
  - If load and mask_q != 0: out_index <= 31 - lz, out_valid <= 1, clear bit (31 - lz) in mask_q.
  - If load and mask_q == 0: out_valid <= 0, done <= 1, go to IDLE.
- Stall (out_valid & ~out_ready): out_index, out_valid and mask_q hold.
- Indices are emitted strictly descending. Each set bit is emitted exactly once.
- All-zero mask: accepted normally. It produces no out_valid, only a done pulse.
- in_ready is 0 throughout SCAN. in_valid during SCAN is ignored and the mask is not captured.
- done is registered. It is high for exactly one cycle, coincident with the first IDLE cycle.
- Reset values: state IDLE, mask_q 0, out_valid 0, out_index 0, done 0, in_ready 1.
- Reset mid-scan: asynchronously aborts the scan. Remaining bits are discarded, no done pulse is generated, and the block returns to IDLE.

## Timing
- Input handshake in cycle T:
  - mask_q is valid in T+1.
  - The first out_valid is in T+2.
- With out_ready held high, a mask with k set bits gives:
  - output handshakes in T+2 .. T+k+1;
  - done and in_ready = 1 in T+k+2.
- Zero mask: done in T+2.
- Throughput is 1 index/cycle. Minimum mask-to-mask spacing is k+2 cycles.
- Each out_ready low cycle extends the scan by one cycle.
- There is no combinational path from out_ready or in_valid to any output. in_ready depends only on state.

## Configuration
- BITMASK_SCAN_LAST_EN defined:
  - adds output port out_last (1 bit, reset 0);
  - out_last is high with out_valid on the final index of a mask, i.e. when the loaded bit was the last set bit in mask_q;
  - out_last holds during stalls.
- Undefined: the port and its logic are absent; all other behaviour is identical.
- A zero mask never asserts out_last in either build.

## Structure
- Shared package/include bitmask_scan_pkg holds:
  - WIDTH and IDX_W constants;
  - the FSM state encoding (S_IDLE = 0, S_SCAN = 1).
- One sub-module instance: the existing leadingZero32 counter, driven combinationally from mask_q. Its 6-bit output value 32 denotes an empty mask.
- Bit clear uses a one-hot decode of 31 - lz and is AND-ed into mask_q.

## Test plan
- in_mask = 32'h8000_0001, out_ready = 1 -> out_index 31 then 0 in consecutive cycles starting T+2; done in T+4; out_last only on 0 (with _EN).
- in_mask = 32'h0000_0000 -> no out_valid; done in T+2; in_ready returns to 1 in T+2.
- in_mask = 32'hFFFF_FFFF with out_ready toggling every other cycle -> 32 indices 31..0, no duplicates or drops; out_index stable while stalled; done once after the last handshake.
- in_valid held high with 32'h0000_00F0 then 32'h0000_0003 queued -> 7,6,5,4, done, then second mask accepted; emits 1,0, done.
- Reset asserted after two indices of 32'h0F00_0000 -> outputs return to reset values immediately; no done pulse; the next mask 32'h0000_0100 emits only 8.
- Random masks, out_ready random -> emitted set equals popcount and bit positions of the input, descending order, done count equals accepted mask count.
